rst_seq_ctrl: RTL and testbench
===============================

# rst_seq_ctrl

Reset sequencing controller for the multi-clock system. It drives the active-low reset inputs of the per-domain reset synchronizers. Domain resets are released one at a time in a fixed order, with a programmable spacing between releases. After power-on, or on a software request, it asserts all domain resets together, holds them for a fixed interval, then releases domain 0, 1, … in order and reports completion.

## Interface
- NUM_DOMAINS, 3, number of sequenced reset domains (≥2).
- HOLD_CYCLES, 4, cycles all domain resets are held asserted before the first release (≥1).
- DLY_WIDTH, 8, width of the release-spacing configuration.

- CLK  in  1  system clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- CFG_DLY  in  DLY_WIDTH  cycles between consecutive domain releases; 0 is treated as 1.
- SW_RST_REQ  in  1  software reset request, sampled each cycle.
- DOM_RST_N  out  NUM_DOMAINS  active-low domain resets; bit i feeds domain i's synchronizer RST.
- STAGE  out  clog2(NUM_DOMAINS)  index of the most recently released domain; 0 while in ASSERT.
- BUSY  out  1  high while a sequence is in progress.
- DONE  out  1  high when all domains are released.

## Operation
- All outputs and state are registered. There are no combinational paths from input to output.
- Internal state:
  - state ∈ {ASSERT, RELEASE, DONE_ST}
  - cnt, width ≥ max(clog2(HOLD_CYCLES), DLY_WIDTH)
  - idx
  - dly_q, DLY_WIDTH bits
- RST high (synchronous), regardless of state:
  - state=ASSERT, cnt=0, idx=0
  - DOM_RST_N=all 0, STAGE=0, BUSY=1, DONE=0
  - dly_q=1
- ASSERT:
  - If cnt==HOLD_CYCLES-1: go to RELEASE, set DOM_RST_N[0]=1, cnt=0, idx=0, dly_q=max(CFG_DLY,1).
  - Otherwise cnt++.
- RELEASE:
  - If cnt==dly_q-1 and idx<NUM_DOMAINS-1: idx++, STAGE=idx+1, DOM_RST_N[idx+1]=1, cnt=0.
  - If cnt==dly_q-1 and idx==NUM_DOMAINS-1: go to DONE_ST, BUSY=0, DONE=1, cnt=0.
  - Otherwise cnt++.
- DONE_ST:
  - On SW_RST_REQ=1: go to ASSERT, DOM_RST_N=all 0, cnt=0, idx=0, STAGE=0, BUSY=1, DONE=0.
  - Otherwise hold.
- SW_RST_REQ while BUSY=1 is ignored. It is not queued and does not restart the sequence.
- CFG_DLY is sampled only on ASSERT→RELEASE. Changes mid-sequence take effect on the next sequence.
- Once a DOM_RST_N bit is set, it stays 1 until the next ASSERT.
- DOM_RST_N is a thermometer code: bit i+1 is never 1 while bit i is 0.
- Invariants:
  - BUSY == !DONE at all times.
  - Exactly one state transition per cycle at most.

## Timing
- E1 is the first rising edge with RST=0.
- DOM_RST_N[0] rises after edge E(HOLD_CYCLES).
- DOM_RST_N[k] rises dly_q edges after DOM_RST_N[k-1].
- DONE rises dly_q edges after DOM_RST_N[NUM_DOMAINS-1].
- Total latency from E1 to DONE = HOLD_CYCLES + NUM_DOMAINS·dly_q edges.
- SW restart: SW_RST_REQ high at the edge while in DONE_ST gives DOM_RST_N=0, BUSY=1, DONE=0 after that same edge. That edge counts as E0, so the release timing above applies with E1 being the following edge.
- SW_RST_REQ held high continuously restarts once per completed sequence. Only a request seen in DONE_ST has effect.
- RST asserted mid-sequence: all domain resets are reasserted at the next edge and the sequence restarts from ASSERT after RST drops.
- RST and SW_RST_REQ high in the same cycle: RST wins. The result is identical to RST alone.

## Test plan
- Power-on, NUM_DOMAINS=3, HOLD_CYCLES=4, CFG_DLY=5, RST released before E1:
  - DOM_RST_N goes 000→001 after E4, →011 after E9, →111 after E14.
  - DONE=1, BUSY=0 after E19.
  - STAGE goes 0, 1, 2.
- CFG_DLY=0: each release is spaced 1 cycle. DOM_RST_N 001/011/111 after E4/E5/E6; DONE after E7.
- CFG_DLY changes 5→2 after E6: sequence keeps 5-cycle spacing. A following SW_RST_REQ restart uses 2-cycle spacing.
- SW_RST_REQ pulse at E10 (BUSY): no effect, timing identical to scenario 1. Pulse while DONE: DOM_RST_N=000, BUSY=1 the next cycle, then the full sequence repeats.
- RST pulsed high at E11 (DOM_RST_N=011): after that edge DOM_RST_N=000, BUSY=1, STAGE=0. On release the sequence restarts, and thermometer order and BUSY==!DONE hold throughout.

Source files
------------

// File: rtl/rst_seq_ctrl_if.sv
// Reset sequencer control/status bundle: configuration and request in, domain resets and status out.
// Purely structural; carries no logic, latency or backpressure of its own.
interface rst_seq_ctrl_if #(
  parameter int NUM_DOMAINS = 3,
  parameter int DLY_WIDTH   = 8
);
  localparam int ST_W = $clog2(NUM_DOMAINS);

  logic [DLY_WIDTH-1:0]   CFG_DLY;
  logic                   SW_RST_REQ;
  logic [NUM_DOMAINS-1:0] DOM_RST_N;
  logic [ST_W-1:0]        STAGE;
  logic                   BUSY;
  logic                   DONE;

  modport master (
    output CFG_DLY, SW_RST_REQ,
    input  DOM_RST_N, STAGE, BUSY, DONE
  );

  modport slave (
    input  CFG_DLY, SW_RST_REQ,
    output DOM_RST_N, STAGE, BUSY, DONE
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domain resets HOLD_CYCLES, then releases domains in order CFG_DLY apart.
// All outputs registered; HOLD_CYCLES + NUM_DOMAINS*max(CFG_DLY,1) edges to DONE; no backpressure.
module rst_seq_ctrl #(
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int DLY_WIDTH   = 8
) (
  input  logic          CLK,
  input  logic          RST,
  rst_seq_ctrl_if.slave bus
);
  localparam int ST_W   = $clog2(NUM_DOMAINS);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int CNT_W  = (DLY_WIDTH > HOLD_W) ? DLY_WIDTH : HOLD_W;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ST_W-1:0]  IDX_LAST  = ST_W'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {ASSERT, RELEASE, DONE_ST} state_t;

  state_t                 state,  state_nxt;
  logic [CNT_W-1:0]       cnt,    cnt_nxt;
  logic [ST_W-1:0]        idx,    idx_nxt;
  logic [DLY_WIDTH-1:0]   dly_q,  dly_nxt;
  logic [NUM_DOMAINS-1:0] dom_q,  dom_nxt;

  logic [DLY_WIDTH-1:0]   dly_m1;
  logic [CNT_W-1:0]       dly_last;

  // dly_q is never 0, so the subtraction cannot wrap
  assign dly_m1   = dly_q - DLY_WIDTH'(1);
  assign dly_last = CNT_W'(dly_m1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ASSERT;
      cnt   <= '0;
      idx   <= '0;
      dly_q <= DLY_WIDTH'(1);
      dom_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      dly_q <= dly_nxt;
      dom_q <= dom_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    dly_nxt   = dly_q;
    dom_nxt   = dom_q;
    case (state)
      ASSERT: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          dom_nxt   = NUM_DOMAINS'(1);
          dly_nxt   = (bus.CFG_DLY == '0) ? DLY_WIDTH'(1) : bus.CFG_DLY;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt == dly_last) begin
          cnt_nxt = '0;
          if (idx == IDX_LAST) begin
            state_nxt = DONE_ST;
          end else begin
            // shifting a 1 in keeps the release pattern a thermometer code
            idx_nxt = idx + ST_W'(1);
            dom_nxt = {dom_q[NUM_DOMAINS-2:0], 1'b1};
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE_ST: begin
        if (bus.SW_RST_REQ) begin
          state_nxt = ASSERT;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          dom_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ASSERT;
        cnt_nxt   = '0;
        idx_nxt   = '0;
        dom_nxt   = '0;
      end
    endcase
  end

  assign bus.DOM_RST_N = dom_q;
  assign bus.STAGE     = idx;
  assign bus.BUSY      = (state != DONE_ST);
  assign bus.DONE      = (state == DONE_ST);
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed scenarios plus random RST/SW_RST_REQ/CFG_DLY traffic,
// scored against an elapsed-edge timeline model.
module tb_rst_seq_ctrl;
  localparam int N    = 3;
  localparam int HOLD = 4;
  localparam int DW   = 8;
  localparam int STW  = $clog2(N);

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  rst_seq_ctrl_if #(.NUM_DOMAINS(N), .DLY_WIDTH(DW)) bus ();

  rst_seq_ctrl #(.NUM_DOMAINS(N), .HOLD_CYCLES(HOLD), .DLY_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic [N-1:0]   dom;
    logic [STW-1:0] st;
    logic           busy;
    logic           done;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // t = edges since the sequence started (0 right after reset/restart); dly = spacing latched at t==HOLD
  int t   = 0;
  int dly = 1;

  function automatic bit model_done();
    return (t >= HOLD + N * dly);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   r;
    r = (t < HOLD) ? 0 : ((t - HOLD) / dly + 1);
    if (r > N) r = N;
    e.dom  = N'((1 << r) - 1);
    e.st   = (r == 0) ? '0 : STW'(r - 1);
    e.done = model_done();
    e.busy = !e.done;
    return e;
  endfunction

  function automatic void model_edge(input logic rst, input logic sw, input logic [DW-1:0] cfg);
    if (rst) begin
      t = 0;
    end else if (model_done()) begin
      if (sw) t = 0;
    end else begin
      t = t + 1;
      if (t == HOLD) dly = (cfg == 0) ? 1 : int'(cfg);
    end
  endfunction

  task automatic step(input logic rst, input logic sw, input logic [DW-1:0] cfg);
    @(negedge CLK);
    RST            = rst;
    bus.SW_RST_REQ = sw;
    bus.CFG_DLY    = cfg;
    @(posedge CLK);
    model_edge(rst, sw, cfg);
    #1 exp_q.push_back(model_out());
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // monitor: every cycle the DUT presents a new registered output set
  always @(negedge CLK) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("dom_rst_n", 32'(bus.DOM_RST_N), 32'(e.dom));
      cmp("stage",     32'(bus.STAGE),     32'(e.st));
      cmp("busy",      32'(bus.BUSY),      32'(e.busy));
      cmp("done",      32'(bus.DONE),      32'(e.done));
    end
  end

  initial begin
    logic [DW-1:0] cfg_r;
    logic          rst_r;
    logic          sw_r;
    bus.SW_RST_REQ = 1'b0;
    bus.CFG_DLY    = DW'(5);

    // power-on, spacing 5, SW request while busy at E10, then a restart from DONE
    repeat (3) step(1'b1, 1'b0, 8'd5);
    for (int i = 1; i <= 24; i++) step(1'b0, i == 10, 8'd5);
    step(1'b0, 1'b1, 8'd5);
    repeat (22) step(1'b0, 1'b0, 8'd5);

    // RST pulse mid-sequence at E11
    step(1'b1, 1'b0, 8'd5);
    for (int i = 1; i <= 32; i++) step(i == 11, 1'b0, 8'd5);

    // CFG_DLY changes 5->2 after E6; next restart picks up 2
    step(1'b1, 1'b0, 8'd5);
    for (int i = 1; i <= 21; i++) step(1'b0, 1'b0, (i <= 6) ? 8'd5 : 8'd2);
    step(1'b0, 1'b1, 8'd2);
    repeat (14) step(1'b0, 1'b0, 8'd2);

    // zero spacing acts as one cycle
    step(1'b1, 1'b0, 8'd0);
    repeat (10) step(1'b0, 1'b0, 8'd0);

    // SW request held high: one restart per completed sequence
    step(1'b1, 1'b0, 8'd1);
    repeat (40) step(1'b0, 1'b1, 8'd1);

    // RST and SW together while DONE: RST wins
    repeat (10) step(1'b0, 1'b0, 8'd1);
    step(1'b1, 1'b1, 8'd1);
    repeat (10) step(1'b0, 1'b0, 8'd1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      rst_r = ($urandom_range(0, 63) == 0);
      sw_r  = ($urandom_range(0, 7) == 0);
      cfg_r = DW'($urandom_range(0, 6));
      step(rst_r, sw_r, cfg_r);
    end

    repeat (2) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain leftover=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
